// File: rtl/ras_stack.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ras_stack                                                  |
// | Description : Return address stack for the fetch-stage branch predictor. |
// |               Circular storage of DEPTH return addresses with overflow   |
// |               wrap, push+pop replace, flush and pointer checkpoint /     |
// |               restore for misprediction recovery.                        |
// | Ports       : clk, rst_n (async, active low)                             |
// |               clear_i                      - flush (empty the stack)     |
// |               restore_i/_tos_i/_cnt_i      - restore pointer checkpoint  |
// |               push_i, push_addr_i          - call: push return address   |
// |               pop_i                        - return: pop predicted target|
// |               top_o, valid_o               - predicted target / non-empty|
// |               ckpt_tos_o, ckpt_cnt_o       - live pointer state          |
// |               overflow_o, underflow_o      - registered one-cycle pulses |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module ras_stack #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             restore_i,
    input  logic [PTR_W-1:0] restore_tos_i,
    input  logic [CNT_W-1:0] restore_cnt_i,
    input  logic             push_i,
    input  logic [XLEN-1:0]  push_addr_i,
    input  logic             pop_i,
    output logic [XLEN-1:0]  top_o,
    output logic             valid_o,
    output logic [PTR_W-1:0] ckpt_tos_o,
    output logic [CNT_W-1:0] ckpt_cnt_o,
    output logic             overflow_o,
    output logic             underflow_o
);

    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] C_ONE   = PTR_W'(1);

    logic [XLEN-1:0]  r_mem [DEPTH];
    logic [PTR_W-1:0] r_tos;
    logic [CNT_W-1:0] r_cnt;
    logic             r_overflow;
    logic             r_underflow;

    logic [PTR_W-1:0] w_tos_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_wr_en;
    logic [PTR_W-1:0] w_wr_idx;
    logic             w_overflow_nxt;
    logic             w_underflow_nxt;
    logic             w_empty;
    logic             w_full;

    assign w_empty = (r_cnt == '0);
    assign w_full  = (r_cnt == C_DEPTH);

    always_comb begin
        w_tos_nxt       = r_tos;
        w_cnt_nxt       = r_cnt;
        w_wr_en         = 1'b0;
        w_wr_idx        = r_tos;
        w_overflow_nxt  = 1'b0;
        w_underflow_nxt = 1'b0;
        if (clear_i) begin
            w_tos_nxt = '0;
            w_cnt_nxt = '0;
        end else if (restore_i) begin
            w_tos_nxt = restore_tos_i;
            // Clamp so an out-of-range checkpoint never yields count > DEPTH.
            w_cnt_nxt = (restore_cnt_i > C_DEPTH) ? C_DEPTH : restore_cnt_i;
        end else if (push_i && pop_i) begin
            // Replace the current top; an empty stack gains its first entry
            // at the current pointer without moving it.
            w_wr_en  = 1'b1;
            w_wr_idx = r_tos;
            if (w_empty) begin
                w_cnt_nxt = CNT_W'(1);
            end
        end else if (push_i) begin
            w_tos_nxt = r_tos + C_ONE;
            w_wr_en   = 1'b1;
            w_wr_idx  = r_tos + C_ONE;
            if (w_full) begin
                // Pointer wrap lands on the oldest entry and overwrites it.
                w_overflow_nxt = 1'b1;
            end else begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
            end
        end else if (pop_i) begin
            if (w_empty) begin
                w_underflow_nxt = 1'b1;
            end else begin
                // Entry is left in place; a later restore may re-expose it.
                w_tos_nxt = r_tos - C_ONE;
                w_cnt_nxt = r_cnt - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tos       <= '0;
            r_cnt       <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_tos       <= w_tos_nxt;
            r_cnt       <= w_cnt_nxt;
            r_overflow  <= w_overflow_nxt;
            r_underflow <= w_underflow_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_mem[w_wr_idx] <= push_addr_i;
        end
    end

    assign valid_o     = !w_empty;
    assign top_o       = w_empty ? '0 : r_mem[r_tos];
    assign ckpt_tos_o  = r_tos;
    assign ckpt_cnt_o  = r_cnt;
    assign overflow_o  = r_overflow;
    assign underflow_o = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_ras_stack.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_ras_stack                                               |
// | Description : Self-checking bench for ras_stack (XLEN=32, DEPTH=8).      |
// |               A reference stack model is compared against the DUT on     |
// |               every falling edge; directed sequences also pin literal    |
// |               expected values.                                           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_ras_stack;

    localparam int XLEN  = 32;
    localparam int DEPTH = 8;
    localparam int PTR_W = 3;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             clear_i;
    logic             restore_i;
    logic [PTR_W-1:0] restore_tos_i;
    logic [CNT_W-1:0] restore_cnt_i;
    logic             push_i;
    logic [XLEN-1:0]  push_addr_i;
    logic             pop_i;
    logic [XLEN-1:0]  top_o;
    logic             valid_o;
    logic [PTR_W-1:0] ckpt_tos_o;
    logic [CNT_W-1:0] ckpt_cnt_o;
    logic             overflow_o;
    logic             underflow_o;

    int n_checks = 0;
    int n_errors = 0;

    ras_stack #(
        .XLEN (XLEN),
        .DEPTH(DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear_i      (clear_i),
        .restore_i    (restore_i),
        .restore_tos_i(restore_tos_i),
        .restore_cnt_i(restore_cnt_i),
        .push_i       (push_i),
        .push_addr_i  (push_addr_i),
        .pop_i        (pop_i),
        .top_o        (top_o),
        .valid_o      (valid_o),
        .ckpt_tos_o   (ckpt_tos_o),
        .ckpt_cnt_o   (ckpt_cnt_o),
        .overflow_o   (overflow_o),
        .underflow_o  (underflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a circular array with a top pointer and an occupancy
    // count, updated directly from the stack rules.
    logic [XLEN-1:0] m_mem [DEPTH];
    int              m_tos;
    int              m_cnt;
    bit              m_ovf;
    bit              m_unf;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) m_mem[i] <= '0;
            m_tos <= 0;
            m_cnt <= 0;
            m_ovf <= 1'b0;
            m_unf <= 1'b0;
        end else begin
            m_ovf <= 1'b0;
            m_unf <= 1'b0;
            if (clear_i) begin
                m_tos <= 0;
                m_cnt <= 0;
            end else if (restore_i) begin
                m_tos <= int'(restore_tos_i);
                m_cnt <= (int'(restore_cnt_i) > DEPTH) ? DEPTH : int'(restore_cnt_i);
            end else if (push_i && pop_i) begin
                m_mem[m_tos] <= push_addr_i;
                if (m_cnt == 0) m_cnt <= 1;
            end else if (push_i) begin
                m_tos <= (m_tos + 1) % DEPTH;
                m_mem[(m_tos + 1) % DEPTH] <= push_addr_i;
                if (m_cnt == DEPTH) m_ovf <= 1'b1;
                else m_cnt <= m_cnt + 1;
            end else if (pop_i) begin
                if (m_cnt == 0) begin
                    m_unf <= 1'b1;
                end else begin
                    m_tos <= (m_tos + DEPTH - 1) % DEPTH;
                    m_cnt <= m_cnt - 1;
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("cyc_top",   64'(top_o),       (m_cnt != 0) ? 64'(m_mem[m_tos]) : 64'(0));
            chk("cyc_valid", 64'(valid_o),     64'(m_cnt != 0));
            chk("cyc_tos",   64'(ckpt_tos_o),  64'(m_tos));
            chk("cyc_cnt",   64'(ckpt_cnt_o),  64'(m_cnt));
            chk("cyc_ovf",   64'(overflow_o),  64'(m_ovf));
            chk("cyc_unf",   64'(underflow_o), 64'(m_unf));
        end
    end

    // Drive one cycle of stimulus; returns #1 after the capturing edge.
    task automatic step(input bit pu, input logic [XLEN-1:0] a, input bit po,
                        input bit cl, input bit rs,
                        input logic [PTR_W-1:0] rt, input logic [CNT_W-1:0] rc);
        @(negedge clk);
        #1;
        push_i        = pu;
        push_addr_i   = a;
        pop_i         = po;
        clear_i       = cl;
        restore_i     = rs;
        restore_tos_i = rt;
        restore_cnt_i = rc;
        @(posedge clk);
        #1;
        push_i        = 1'b0;
        push_addr_i   = '0;
        pop_i         = 1'b0;
        clear_i       = 1'b0;
        restore_i     = 1'b0;
        restore_tos_i = '0;
        restore_cnt_i = '0;
    endtask

    task automatic do_push(input logic [XLEN-1:0] a);
        step(1'b1, a, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic do_pop();
        step(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic do_idle();
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    logic [PTR_W-1:0] cap_tos;
    logic [CNT_W-1:0] cap_cnt;

    initial begin
        rst_n         = 1'b0;
        clear_i       = 1'b0;
        restore_i     = 1'b0;
        restore_tos_i = '0;
        restore_cnt_i = '0;
        push_i        = 1'b0;
        push_addr_i   = '0;
        pop_i         = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        chk("rst_top",   64'(top_o),       64'h0);
        chk("rst_valid", 64'(valid_o),     64'h0);
        chk("rst_cnt",   64'(ckpt_cnt_o),  64'h0);
        chk("rst_tos",   64'(ckpt_tos_o),  64'h0);
        chk("rst_ovf",   64'(overflow_o),  64'h0);
        chk("rst_unf",   64'(underflow_o), 64'h0);

        // Basic push/pop
        do_push(32'h100);
        do_push(32'h200);
        do_push(32'h300);
        chk("basic_top3", 64'(top_o), 64'h300);
        chk("basic_cnt3", 64'(ckpt_cnt_o), 64'd3);
        do_pop();
        chk("basic_top2", 64'(top_o), 64'h200);
        chk("basic_cnt2", 64'(ckpt_cnt_o), 64'd2);
        do_pop();
        do_pop();
        chk("basic_valid0", 64'(valid_o), 64'h0);
        chk("basic_top0",   64'(top_o),   64'h0);

        // Overflow: 9 pushes into an 8-deep stack
        for (int i = 1; i <= 9; i++) begin
            do_push(32'(4 * i));
            chk("ovf_pulse", 64'(overflow_o), (i == 9) ? 64'h1 : 64'h0);
        end
        chk("ovf_cnt", 64'(ckpt_cnt_o), 64'd8);
        chk("ovf_top", 64'(top_o), 64'h24);
        do_idle();
        chk("ovf_clear", 64'(overflow_o), 64'h0);
        for (int i = 0; i < 8; i++) begin
            chk("ovf_pop_top", 64'(top_o), 64'(32'h24 - 32'(4 * i)));
            do_pop();
        end
        chk("ovf_empty", 64'(valid_o), 64'h0);
        do_pop();
        chk("unf_pulse", 64'(underflow_o), 64'h1);
        chk("unf_cnt",   64'(ckpt_cnt_o),  64'd0);
        chk("unf_tos",   64'(ckpt_tos_o),  64'd1);
        do_idle();
        chk("unf_clear", 64'(underflow_o), 64'h0);

        // Push+pop replace
        do_push(32'h40);
        do_push(32'h80);
        step(1'b1, 32'hC0, 1'b1, 1'b0, 1'b0, '0, '0);
        chk("rep_top", 64'(top_o), 64'hC0);
        chk("rep_cnt", 64'(ckpt_cnt_o), 64'd2);
        do_pop();
        chk("rep_pop_top", 64'(top_o), 64'h40);
        do_pop();
        step(1'b1, 32'h50, 1'b1, 1'b0, 1'b0, '0, '0);
        chk("rep_empty_cnt", 64'(ckpt_cnt_o),  64'd1);
        chk("rep_empty_top", 64'(top_o),       64'h50);
        chk("rep_empty_unf", 64'(underflow_o), 64'h0);

        // Checkpoint / restore
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, '0, '0);
        do_push(32'h40);
        do_push(32'h80);
        chk("ck_cnt", 64'(ckpt_cnt_o), 64'd2);
        chk("ck_tos", 64'(ckpt_tos_o), 64'd2);
        cap_tos = ckpt_tos_o;
        cap_cnt = ckpt_cnt_o;
        do_push(32'h90);
        do_push(32'hA0);
        do_pop();
        step(1'b1, 32'hDEAD, 1'b0, 1'b0, 1'b1, cap_tos, cap_cnt);
        chk("rs_cnt", 64'(ckpt_cnt_o), 64'd2);
        chk("rs_tos", 64'(ckpt_tos_o), 64'd2);
        chk("rs_top", 64'(top_o), 64'h80);

        // Clear beats restore and push; restore count is clamped
        step(1'b1, 32'h77, 1'b0, 1'b1, 1'b1, 3'd5, 4'd3);
        chk("clr_cnt",   64'(ckpt_cnt_o), 64'd0);
        chk("clr_valid", 64'(valid_o),    64'h0);
        chk("clr_ovf",   64'(overflow_o), 64'h0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, 3'd3, 4'd15);
        chk("clamp_cnt", 64'(ckpt_cnt_o), 64'd8);
        chk("clamp_top", 64'(top_o), 64'h90);

        // Asynchronous reset mid-sequence
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, '0, '0);
        for (int i = 0; i < 5; i++) do_push(32'h1000 + 32'(i));
        chk("ar_cnt5", 64'(ckpt_cnt_o), 64'd5);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_top",   64'(top_o),      64'h0);
        chk("ar_valid", 64'(valid_o),    64'h0);
        chk("ar_cnt",   64'(ckpt_cnt_o), 64'd0);
        chk("ar_tos",   64'(ckpt_tos_o), 64'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        do_push(32'h10);
        chk("ar_push_cnt", 64'(ckpt_cnt_o), 64'd1);
        chk("ar_push_top", 64'(top_o), 64'h10);
        do_idle();
        do_idle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ras_stack.md
Name: ras_stack

Overview:
- Parametrised return address stack (RAS) for the fetch-stage branch predictor.
- Pushes the link address on a call (JAL/JALR with rd=x1/x5) and pops the predicted target on a return.
- Generalises fixed RAS_SIZE=8 into a depth/width-parametrised circular stack with overflow wrap, simultaneous push+pop (replace), flush, and pointer checkpoint/restore for misprediction recovery.
- Sits beside the BTB in IF; the restore inputs are driven from EX on branch resolution.

Parameters:
- XLEN, 32, width of stored return addresses.
- DEPTH, 8, number of entries; power of two, at least 2.
- PTR_W, $clog2(DEPTH), top-of-stack pointer width.
- CNT_W, $clog2(DEPTH+1), occupancy counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear_i  in  1  flush: empty the stack.
- restore_i  in  1  restore pointer state from a checkpoint.
- restore_tos_i  in  PTR_W  checkpointed top-of-stack pointer.
- restore_cnt_i  in  CNT_W  checkpointed occupancy.
- push_i  in  1  call predicted/fetched.
- push_addr_i  in  XLEN  return address to push (call PC+4).
- pop_i  in  1  return predicted/fetched.
- top_o  out  XLEN  predicted return target; mem[tos] when valid, else 0.
- valid_o  out  1  count != 0.
- ckpt_tos_o  out  PTR_W  current tos_q, for checkpointing.
- ckpt_cnt_o  out  CNT_W  current cnt_q, for checkpointing.
- overflow_o  out  1  one-cycle registered pulse: a push overwrote the oldest entry.
- underflow_o  out  1  one-cycle registered pulse: a pop occurred on an empty stack.

Behaviour:
- Reset (rst_n low, asynchronous):
  - tos_q=0, cnt_q=0, all entries=0.
  - overflow_o=0, underflow_o=0.
  - top_o=0, valid_o=0.
- Storage is a circular array mem[0..DEPTH-1]. tos_q points at the newest valid entry. Pointer arithmetic is modulo DEPTH (natural PTR_W wrap).
- Outputs top_o, valid_o and ckpt_* are combinational from registered state, with zero-cycle read latency. A push in cycle N is visible on top_o in cycle N+1.
- Priority per cycle: clear_i > restore_i > push/pop.
- clear_i: cnt_q<=0, tos_q<=0; entries untouched; push/pop ignored; no flag pulses.
- restore_i:
  - tos_q<=restore_tos_i.
  - cnt_q<=min(restore_cnt_i, DEPTH).
  - Entries untouched; push/pop ignored; no flag pulses.
- Push only:
  - tos_q<=tos_q+1; mem[tos_q+1]<=push_addr_i.
  - If cnt_q<DEPTH, cnt_q+1.
  - If cnt_q==DEPTH, count stays DEPTH, the oldest entry is overwritten, and overflow_o=1 next cycle.
- Pop only:
  - If cnt_q>0: tos_q<=tos_q-1, cnt_q-1; entry not erased.
  - If cnt_q==0: no state change, underflow_o=1 next cycle.
- Push and pop together (return immediately followed by call, or tail call):
  - If cnt_q>0: mem[tos_q]<=push_addr_i; tos_q and cnt_q unchanged; no flags.
  - If cnt_q==0: mem[tos_q]<=push_addr_i, cnt_q<=1, tos_q unchanged; no underflow.
- Flag pulses last exactly one cycle unless the condition repeats.
- Restore after wrap-around may expose overwritten entries. This is accepted predictor inaccuracy, not an error.
- No X on outputs after reset; illegal restore_cnt_i values are clamped, never propagated.

Test Plan:
- Reset, then push 0x100, 0x200, 0x300 -> top_o=0x300, cnt=3; pop -> top_o=0x200, cnt=2; pop, pop -> valid_o=0, top_o=0.
- DEPTH=8: push 0x04..0x24 (9 pushes, step 4) -> overflow_o pulses after the 9th push only, cnt=8, top_o=0x24; 8 pops return 0x24..0x08, 9th pop -> underflow_o one pulse, state unchanged.
- Stack holding [0x40, 0x80]: push+pop with push_addr_i=0xC0 -> top_o=0xC0, cnt=2; one pop -> top_o=0x40. On an empty stack, push+pop with 0x50 -> cnt=1, top_o=0x50, no underflow.
- Capture ckpt at cnt=2 (top 0x80); push 0x90, 0xA0, pop; restore_i with the captured values -> cnt=2, tos restored, top_o equals mem[restored tos]. Same cycle as push_i -> push ignored.
- clear_i asserted together with restore_i and push_i -> cnt=0, valid_o=0, no flags. restore_cnt_i=15 with DEPTH=8 -> cnt=8.
- Assert rst_n low mid-sequence (cnt=5), asynchronously between edges -> outputs zero immediately. After release, first push 0x10 -> cnt=1, top_o=0x10.
